// File: rtl/uart_rx_deserializer_if.sv
// Byte-side output bundle of the UART receiver toward the command parser.
// master drives the byte and the two strobes; slave observes them.
interface uart_rx_deserializer_if;
    logic [7:0] rx_byte;
    logic       received;
    logic       rx_error;
    logic       is_receiving;

    modport master (output rx_byte, output received, output rx_error, output is_receiving);
    modport slave  (input  rx_byte, input  received, input  rx_error, input  is_receiving);
endinterface

// File: rtl/uart_rx_deserializer.sv
// 16x oversampling 8N1 UART receiver with glitch rejection, majority-vote sampling and framing check.
// Latency: received strobe 3 + 154*DIV cycles after the line's falling start edge.
// No backpressure: the byte and strobe are presented for one cycle and must be taken then.
module uart_rx_deserializer #(
    parameter int CLOCK_RATE = 50000000,
    parameter int BAUDRATE   = 115200
) (
    input  logic clk,
    input  logic rst,
    input  logic i_rx,
    uart_rx_deserializer_if.master rx_out
);
    localparam int DIV = CLOCK_RATE / (BAUDRATE * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START      = 3'd1;
    localparam logic [2:0] DATA       = 3'd2;
    localparam logic [2:0] STOP       = 3'd3;
    localparam logic [2:0] BREAK_WAIT = 3'd4;

    if (DIV < 2) begin : g_div_check
        $error("uart_rx_deserializer: CLOCK_RATE/(BAUDRATE*16) must be at least 2");
    end

    logic [1:0]    rx_sync;
    logic          rx_s;
    logic          rx_d;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [3:0]    sub;
    logic [2:0]    bit_idx;
    logic          s7;
    logic          s8;
    logic          maj;
    logic [7:0]    shreg;
    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          start_edge;
    logic [7:0]    rx_byte_q;
    logic          received_q;
    logic          rx_error_q;
    logic          is_receiving_q;

    assign rx_s       = rx_sync[1];
    assign tick       = (cnt == CNT_MAX);
    assign start_edge = (state == IDLE) && rx_d && !rx_s;
    // The third vote is the live sample taken on the sub=9 tick itself.
    assign maj        = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_sync <= 2'b11;
            rx_d    <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], i_rx};
            rx_d    <= rx_s;
        end
    end

    // Restarting the divider on the start edge centres the sub=7..9 samples in each bit.
    always_ff @(posedge clk) begin
        if (!rst)                    cnt <= '0;
        else if (start_edge || tick) cnt <= '0;
        else                         cnt <= cnt + CW'(1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (rx_d && !rx_s) state_nxt = START;
            START: begin
                if (tick && sub == 4'd9 && maj) state_nxt = IDLE;
                else if (tick && sub == 4'd15)  state_nxt = DATA;
            end
            DATA:       if (tick && sub == 4'd15 && bit_idx == 3'd7) state_nxt = STOP;
            STOP:       if (tick && sub == 4'd9) state_nxt = maj ? IDLE : BREAK_WAIT;
            BREAK_WAIT: if (rx_s) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            sub            <= 4'd0;
            bit_idx        <= 3'd0;
            s7             <= 1'b0;
            s8             <= 1'b0;
            shreg          <= 8'h00;
            rx_byte_q      <= 8'h00;
            received_q     <= 1'b0;
            rx_error_q     <= 1'b0;
            is_receiving_q <= 1'b0;
        end else begin
            state          <= state_nxt;
            is_receiving_q <= (state_nxt != IDLE);
            received_q     <= 1'b0;
            rx_error_q     <= 1'b0;
            if (state == IDLE) begin
                sub     <= 4'd0;
                bit_idx <= 3'd0;
            end else if (tick) begin
                sub <= sub + 4'd1;
                if (sub == 4'd7) s7 <= rx_s;
                if (sub == 4'd8) s8 <= rx_s;
                if (sub == 4'd15 && state == DATA) bit_idx <= bit_idx + 3'd1;
                if (sub == 4'd9) begin
                    if (state == DATA) shreg <= {maj, shreg[7:1]};
                    if (state == STOP) begin
                        if (maj) begin
                            rx_byte_q  <= shreg;
                            received_q <= 1'b1;
                        end else begin
                            rx_error_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign rx_out.rx_byte      = rx_byte_q;
    assign rx_out.received     = received_q;
    assign rx_out.rx_error     = rx_error_q;
    assign rx_out.is_receiving = is_receiving_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at DIV=10 (160 cycles per bit).
module tb_uart_rx_deserializer;
    localparam int BIT = 160;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_rx = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   t0;

    logic [7:0] rcv_q[$];
    int         rcv_cyc_q[$];
    int         err_cyc_q[$];

    uart_rx_deserializer_if rx_if();

    uart_rx_deserializer #(.CLOCK_RATE(18432000), .BAUDRATE(115200)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_rx   (i_rx),
        .rx_out (rx_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (rx_if.received) begin
            rcv_q.push_back(rx_if.rx_byte);
            rcv_cyc_q.push_back(cyc);
        end
        if (rx_if.rx_error) err_cyc_q.push_back(cyc);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        else n_pass++;
    endtask

    task automatic clear_obs();
        rcv_q.delete();
        rcv_cyc_q.delete();
        err_cyc_q.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is positioned 1 time unit after a posedge; t0 marks the start edge cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        t0 = cyc;
        i_rx = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            wait_cyc(BIT);
        end
        i_rx = stop_val;
        wait_cyc(BIT);
    endtask

    function automatic int first_lat(input int base);
        return (rcv_cyc_q.size() > 0) ? rcv_cyc_q[0] - base : -1;
    endfunction

    initial begin
        int t_a;
        wait_cyc(5);
        chk("reset_rx_byte", rx_if.rx_byte, 8'h00);
        chk("reset_received", rx_if.received, 0);
        chk("reset_rx_error", rx_if.rx_error, 0);
        chk("reset_is_receiving", rx_if.is_receiving, 0);
        rst = 1'b1;
        wait_cyc(20);

        // Single byte 'L'
        clear_obs();
        send_frame(8'h4C, 1'b1);
        wait_cyc(50);
        chk("L_strobe_cycles", rcv_q.size(), 1);
        chk("L_byte", (rcv_q.size() > 0) ? int'(rcv_q[0]) : -1, 8'h4C);
        chk("L_latency", first_lat(t0), 1543);
        chk("L_no_error", err_cyc_q.size(), 0);
        chk("L_idle_after", rx_if.is_receiving, 0);

        // Back-to-back frames
        clear_obs();
        send_frame(8'h30, 1'b1);
        t_a = t0;
        send_frame(8'h46, 1'b1);
        wait_cyc(50);
        chk("b2b_count", rcv_q.size(), 2);
        chk("b2b_first", (rcv_q.size() > 0) ? int'(rcv_q[0]) : -1, 8'h30);
        chk("b2b_second", (rcv_q.size() > 1) ? int'(rcv_q[1]) : -1, 8'h46);
        chk("b2b_first_latency", first_lat(t_a), 1543);
        chk("b2b_spacing", (rcv_cyc_q.size() > 1) ? rcv_cyc_q[1] - rcv_cyc_q[0] : -1, 1600);

        // Glitch shorter than half a bit
        clear_obs();
        i_rx = 1'b0;
        wait_cyc(30);
        i_rx = 1'b1;
        wait_cyc(60);
        chk("glitch_busy_mid", rx_if.is_receiving, 1);
        wait_cyc(20);
        chk("glitch_idle_after", rx_if.is_receiving, 0);
        wait_cyc(1700);
        chk("glitch_no_rx", rcv_q.size(), 0);
        chk("glitch_no_err", err_cyc_q.size(), 0);

        // Framing error, stop bit low then held a bit longer
        clear_obs();
        send_frame(8'hA5, 1'b0);
        wait_cyc(300);
        chk("ferr_hold_busy", rx_if.is_receiving, 1);
        chk("ferr_err_count", err_cyc_q.size(), 1);
        chk("ferr_err_latency", (err_cyc_q.size() > 0) ? err_cyc_q[0] - t0 : -1, 1543);
        i_rx = 1'b1;
        wait_cyc(200);
        chk("ferr_no_rx", rcv_q.size(), 0);
        chk("ferr_byte_kept", rx_if.rx_byte, 8'h46);
        chk("ferr_idle_after", rx_if.is_receiving, 0);

        // Line break
        clear_obs();
        i_rx = 1'b0;
        wait_cyc(5000);
        chk("break_err_count", err_cyc_q.size(), 1);
        chk("break_still_busy", rx_if.is_receiving, 1);
        i_rx = 1'b1;
        wait_cyc(300);
        chk("break_released_idle", rx_if.is_receiving, 0);
        send_frame(8'h53, 1'b1);
        wait_cyc(50);
        chk("break_then_S_count", rcv_q.size(), 1);
        chk("break_then_S_byte", (rcv_q.size() > 0) ? int'(rcv_q[0]) : -1, 8'h53);
        chk("break_no_extra_err", err_cyc_q.size(), 1);

        // Reset during bit 4 of 0xFF
        clear_obs();
        i_rx = 1'b0;
        wait_cyc(BIT);
        i_rx = 1'b1;
        wait_cyc(4 * BIT + 80);
        chk("pre_reset_busy", rx_if.is_receiving, 1);
        rst = 1'b0;
        wait_cyc(1);
        chk("mid_reset_rx_byte", rx_if.rx_byte, 8'h00);
        chk("mid_reset_is_receiving", rx_if.is_receiving, 0);
        chk("mid_reset_received", rx_if.received, 0);
        chk("mid_reset_rx_error", rx_if.rx_error, 0);
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(1200);
        chk("post_reset_no_rx", rcv_q.size(), 0);
        chk("post_reset_no_err", err_cyc_q.size(), 0);
        send_frame(8'h0A, 1'b1);
        wait_cyc(50);
        chk("post_reset_count", rcv_q.size(), 1);
        chk("post_reset_byte", (rcv_q.size() > 0) ? int'(rcv_q[0]) : -1, 8'h0A);
        chk("post_reset_latency", first_lat(t0), 1543);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
